// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: instruction-fetch / decode front-end sequencer for the RV32 core.
// Owns the PC, issues instruction-memory requests, holds the fetched word in the
// instruction register feeding the decoder, and presents it to execute with a
// valid/ready handshake. Handles redirects, illegal-instruction traps and fetch timeouts.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module fetch_decode_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0200_0000,
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        boot_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dec_inst,
    output logic        dec_en,
    input  logic        dec_illegal,
    output logic        id_valid,
    output logic [31:0] id_pc,
    input  logic        ex_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        illegal_trap,
    output logic        bus_err,
    output logic [31:0] trap_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    // Last counter value before a WAIT/DRAIN timeout fires (counter starts at 0 on grant).
    localparam logic [7:0] TMO_LAST = 8'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_TRAP,
        ST_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [7:0]  r_cnt;
    logic [31:0] r_dec_inst;
    logic        r_dec_en;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic        r_illegal_trap;
    logic        r_bus_err;
    logic [31:0] r_trap_pc;

    // Control strobes produced by the FSM and consumed by the datapath registers.
    logic        w_take_redirect;
    logic        w_capture;
    logic        w_hs_ok;
    logic        w_hs_ill;
    logic        w_timeout;
    logic        w_cnt_clr;
    logic        w_cnt_inc;
    logic        w_cnt_last;
    logic        w_handshake;
    logic [31:0] w_redirect_aligned;

    assign w_cnt_last         = (r_cnt == TMO_LAST);
    assign w_handshake        = r_id_valid & ex_ready;
    assign w_redirect_aligned = redirect_pc & ~32'd3;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a redirect outranks every other event except in IDLE.
    always_comb begin
        w_state_nxt     = r_state;
        w_take_redirect = 1'b0;
        w_capture       = 1'b0;
        w_hs_ok         = 1'b0;
        w_hs_ill        = 1'b0;
        w_timeout       = 1'b0;
        w_cnt_clr       = 1'b0;
        w_cnt_inc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (boot_en) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    w_take_redirect = 1'b1;
                    // A grant in the same cycle leaves a response in flight to discard.
                    if (imem_gnt) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end else if (imem_gnt) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    w_take_redirect = 1'b1;
                    w_state_nxt     = ST_DRAIN;
                    w_cnt_clr       = 1'b1;
                end else if (imem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (w_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_TRAP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_take_redirect = 1'b1;
                    w_state_nxt     = ST_REQ;
                end else if (w_handshake) begin
                    if (dec_illegal) begin
                        w_hs_ill    = 1'b1;
                        w_state_nxt = ST_TRAP;
                    end else begin
                        w_hs_ok     = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_TRAP: begin
                if (redirect_valid) begin
                    w_take_redirect = 1'b1;
                    w_state_nxt     = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    w_take_redirect = 1'b1;
                    w_state_nxt     = ST_REQ;
                end else if (imem_rvalid || w_cnt_last) begin
                    // Stale word dropped, or it never came; either way refetch silently.
                    w_state_nxt = ST_REQ;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // PC, instruction register, timeout counter and trap reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= RESET_PC;
            r_cnt          <= 8'd0;
            r_dec_inst     <= 32'd0;
            r_dec_en       <= 1'b0;
            r_id_valid     <= 1'b0;
            r_id_pc        <= RESET_PC;
            r_illegal_trap <= 1'b0;
            r_bus_err      <= 1'b0;
            r_trap_pc      <= 32'd0;
        end else begin
            r_illegal_trap <= w_hs_ill;
            r_bus_err      <= w_timeout;

            if (w_cnt_clr) begin
                r_cnt <= 8'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_take_redirect) begin
                r_pc       <= w_redirect_aligned;
                r_dec_inst <= 32'd0;
                r_dec_en   <= 1'b0;
                r_id_valid <= 1'b0;
            end else if (w_capture) begin
                r_dec_inst <= imem_rdata;
                r_dec_en   <= 1'b1;
                r_id_valid <= 1'b1;
                r_id_pc    <= r_pc;
                r_pc       <= r_pc + 32'd4;
            end else if (w_hs_ok || w_hs_ill) begin
                r_dec_inst <= 32'd0;
                r_dec_en   <= 1'b0;
                r_id_valid <= 1'b0;
            end

            if (w_timeout) begin
                r_trap_pc <= r_pc;
            end else if (w_hs_ill) begin
                r_trap_pc <= r_id_pc;
            end
        end
    end

    assign imem_req     = (r_state == ST_REQ);
    assign imem_addr    = r_pc;
    assign dec_inst     = r_dec_inst;
    assign dec_en       = r_dec_en;
    assign id_valid     = r_id_valid;
    assign id_pc        = r_id_pc;
    assign illegal_trap = r_illegal_trap;
    assign bus_err      = r_bus_err;
    assign trap_pc      = r_trap_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = ((r_state == ST_REQ) && !imem_gnt) ||
                     (r_state == ST_WAIT) ||
                     ((r_state == ST_HOLD) && !ex_ready);

    // Free-running event counters; both wrap at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if ((r_state == ST_HOLD) && w_handshake) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Testbench for fetch_decode_ctrl: directed scenarios followed by a randomized
// run against a transaction-level model of the expected PC / instruction stream.
module tb_fetch_decode_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0200_0000;
    localparam int unsigned TMO      = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] dec_inst;
    logic        dec_en;
    logic        dec_illegal;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        ex_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal_trap;
    logic        bus_err;
    logic [31:0] trap_pc;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    fetch_decode_ctrl #(
        .RESET_PC     (RESET_PC),
        .WAIT_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .boot_en        (boot_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .dec_inst       (dec_inst),
        .dec_en         (dec_en),
        .dec_illegal    (dec_illegal),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .ex_ready       (ex_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .illegal_trap   (illegal_trap),
        .bus_err        (bus_err),
        .trap_pc        (trap_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".req"},     32'(imem_req),     32'd0);
        chk({tag, ".addr"},    imem_addr,         RESET_PC);
        chk({tag, ".inst"},    dec_inst,          32'd0);
        chk({tag, ".en"},      32'(dec_en),       32'd0);
        chk({tag, ".valid"},   32'(id_valid),     32'd0);
        chk({tag, ".id_pc"},   id_pc,             RESET_PC);
        chk({tag, ".illtrap"}, 32'(illegal_trap), 32'd0);
        chk({tag, ".buserr"},  32'(bus_err),      32'd0);
        chk({tag, ".trap_pc"}, trap_pc,           32'd0);
    endtask

    // Memory contents seen by the randomized phase: any fixed address-derived word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h3C5A};
    endfunction

    // Randomized-phase model state.
    logic [31:0] exp_fetch;
    logic [31:0] exp_exec;
    logic [31:0] o_addr;
    logic [31:0] tgt;
    logic        outstanding;
    int unsigned dly;
    logic        gnt_n;
    logic        rv_n;
    logic        rdy_n;
    logic        redir_n;
    int          n_hs;

    initial begin
        rst_n          = 1'b0;
        boot_en        = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        dec_illegal    = 1'b0;
        ex_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        #12;
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // Boot and first fetch with immediate grant/response/ready.
        boot_en = 1'b1;
        tick();
        boot_en = 1'b0;
        chk("boot.req",  32'(imem_req), 32'd1);
        chk("boot.addr", imem_addr, 32'h0200_0000);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("boot.wait_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0797;
        tick();
        imem_rvalid = 1'b0;
        chk("boot.inst",  dec_inst, 32'h0000_0797);
        chk("boot.en",    32'(dec_en), 32'd1);
        chk("boot.valid", 32'(id_valid), 32'd1);
        chk("boot.id_pc", id_pc, 32'h0200_0000);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        chk("boot.clr",   dec_inst, 32'd0);
        chk("boot.nreq",  32'(imem_req), 32'd1);
        chk("boot.naddr", imem_addr, 32'h0200_0004);

        // Backpressure: instruction held while execute stalls.
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h02c7_8793;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            chk("bp.inst", dec_inst, 32'h02c7_8793);
            chk("bp.req",  32'(imem_req), 32'd0);
            tick();
        end
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        chk("bp.clr",   dec_inst, 32'd0);
        chk("bp.req2",  32'(imem_req), 32'd1);
        chk("bp.addr2", imem_addr, 32'h0200_0008);

        // Illegal instruction retires into a trap.
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0000;
        tick();
        imem_rvalid = 1'b0;
        chk("ill.id_pc", id_pc, 32'h0200_0008);
        dec_illegal = 1'b1;
        ex_ready    = 1'b1;
        tick();
        dec_illegal = 1'b0;
        ex_ready    = 1'b0;
        chk("ill.pulse",   32'(illegal_trap), 32'd1);
        chk("ill.trap_pc", trap_pc, 32'h0200_0008);
        chk("ill.valid",   32'(id_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ill.once",  32'(illegal_trap), 32'd0);
            chk("ill.noreq", 32'(imem_req), 32'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0200_002E;
        tick();
        redirect_valid = 1'b0;
        chk("ill.rd_req",  32'(imem_req), 32'd1);
        chk("ill.rd_addr", imem_addr, 32'h0200_002C);

        // Redirect while a response is outstanding; the late word is dropped.
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0200_00CC;
        tick();
        redirect_valid = 1'b0;
        chk("rw.noreq", 32'(imem_req), 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1a50_00ef;
        tick();
        imem_rvalid = 1'b0;
        chk("rw.valid", 32'(id_valid), 32'd0);
        chk("rw.inst",  dec_inst, 32'd0);
        chk("rw.req",   32'(imem_req), 32'd1);
        chk("rw.addr",  imem_addr, 32'h0200_00CC);
        tick();
        chk("rw.valid2", 32'(id_valid), 32'd0);

        // Timeout: response never arrives.
        chk("tmo.req", 32'(imem_req), 32'd1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 1; i < int'(TMO); i++) begin
            tick();
            chk("tmo.early", 32'(bus_err), 32'd0);
        end
        tick();
        chk("tmo.pulse",   32'(bus_err), 32'd1);
        chk("tmo.trap_pc", trap_pc, 32'h0200_00CC);
        tick();
        chk("tmo.once",  32'(bus_err), 32'd0);
        chk("tmo.noreq", 32'(imem_req), 32'd0);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        tick();
        imem_rvalid = 1'b0;
        chk("wrap.id_pc", id_pc, 32'hFFFF_FFFC);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        chk("wrap.naddr", imem_addr, 32'h0000_0000);

        // Asynchronous reset in the middle of a WAIT.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        #2;
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        chk("arst.idle_req",   32'(imem_req), 32'd0);
        chk("arst.idle_valid", 32'(id_valid), 32'd0);
        chk("arst.idle_inst",  dec_inst, 32'd0);

        // Randomized traffic against the instruction-stream model.
        boot_en = 1'b1;
        tick();
        boot_en     = 1'b0;
        exp_fetch   = RESET_PC;
        exp_exec    = RESET_PC;
        outstanding = 1'b0;
        dly         = 0;
        o_addr      = 32'd0;
        n_hs        = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!id_valid) begin
                chk("rnd.idle_out", {dec_inst[31:1], dec_inst[0] | dec_en}, 32'd0);
            end

            rv_n = 1'b0;
            if (outstanding) begin
                if (dly == 0) begin
                    rv_n        = 1'b1;
                    outstanding = 1'b0;
                end else begin
                    dly = dly - 1;
                end
            end

            redir_n = 1'b0;
            if (!outstanding && !rv_n && ($urandom_range(0, 19) == 0)) begin
                redir_n = 1'b1;
            end

            gnt_n = 1'b0;
            if (imem_req && !redir_n) begin
                gnt_n = 1'($urandom_range(0, 1));
            end
            if (gnt_n) begin
                chk("rnd.fetch_addr", imem_addr, exp_fetch);
                exp_fetch   = exp_fetch + 32'd4;
                o_addr      = imem_addr;
                outstanding = 1'b1;
                dly         = $urandom_range(0, 3);
            end

            rdy_n = ($urandom_range(0, 2) != 0);
            if (id_valid && rdy_n && !redir_n) begin
                chk("rnd.id_pc", id_pc, exp_exec);
                chk("rnd.inst",  dec_inst, mem_word(exp_exec));
                chk("rnd.en",    32'(dec_en), 32'd1);
                exp_exec = exp_exec + 32'd4;
                n_hs++;
            end

            tgt = $urandom;
            if (redir_n) begin
                exp_fetch = tgt & ~32'd3;
                exp_exec  = tgt & ~32'd3;
            end

            imem_gnt       = gnt_n;
            imem_rvalid    = rv_n;
            imem_rdata     = rv_n ? mem_word(o_addr) : $urandom;
            ex_ready       = rdy_n;
            redirect_valid = redir_n;
            redirect_pc    = tgt;
            tick();
        end
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        ex_ready       = 1'b0;
        redirect_valid = 1'b0;
        chk("rnd.progress", 32'(n_hs >= 100), 32'd1);
        chk("rnd.no_trap",  32'(illegal_trap | bus_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
